calc_core_param: RTL and testbench

- Parametrised successor to the fixed 16-bit calculator: a WIDTH-bit integer ALU loaded and read through an 8-bit byte-serial command port, so it fits the 8-bit pin budget of the top-level wrapper.
- Adds iterative multiply, divide and modulo (multi-cycle, busy/done handshake) and a status-flag output.
- Sits directly under the top-level pin wrapper, which maps ui_in/uio_in/uo_out onto the command and result ports.

---
 rtl/calc_pkg.sv | 48 ++++
 rtl/calc_muldiv_iter.sv | 105 ++++++++++
 rtl/calc_core_param.sv | 195 +++++++++++++++++++
 tb/tb_calc_core_param.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared encodings for the byte-serial calculator core.
// Revision    : 1.0
// ============================================================================
package calc_pkg;

    localparam logic [1:0] CMD_LDA  = 2'b00;
    localparam logic [1:0] CMD_LDB  = 2'b01;
    localparam logic [1:0] CMD_EXEC = 2'b10;
    localparam logic [1:0] CMD_RD   = 2'b11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_DIVZERO = 3;

    function automatic logic [3:0] pack_flags(input logic divzero, input logic ovf,
                                              input logic carry, input logic zero);
        logic [3:0] f;
        f               = '0;
        f[FLAG_DIVZERO] = divzero;
        f[FLAG_OVF]     = ovf;
        f[FLAG_CARRY]   = carry;
        f[FLAG_ZERO]    = zero;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : calc_muldiv_iter
// Description : Shared WIDTH-step shift-add multiplier / restoring divider.
// Revision    : 1.0
// ============================================================================
module calc_muldiv_iter
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    // hi:lo is the 2*WIDTH accumulator (MUL) or remainder:quotient (DIV).
    always_comb begin
        w_add    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a} : {(WIDTH + 1){1'b0}});
        w_rem_sh = {hi_q, lo_q[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, b};
        if (mode_q == MODE_DIV) begin
            if (!w_trial[WIDTH]) begin
                w_step_hi = w_trial[WIDTH-1:0];
                w_step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_rem_sh[WIDTH-1:0];
                w_step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_add[WIDTH:1];
            w_step_lo = {w_add[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        busy_d = busy_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (start) begin
            busy_d = 1'b1;
            mode_d = mode;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = (mode == MODE_DIV) ? a : b;
        end else if (busy_q && ena) begin
            hi_d  = w_step_hi;
            lo_d  = w_step_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            mode_q <= MODE_MUL;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // done flags the final step; lo/hi carry that step's result so the
    // parent can capture it on the same edge the iteration ends.
    assign busy = busy_q;
    assign done = busy_q && ena && (cnt_q == LAST);
    assign lo   = w_step_lo;
    assign hi   = w_step_hi;

endmodule
`default_nettype wire

// File: rtl/calc_core_param.sv
`default_nettype none
// ============================================================================
// Module      : calc_core_param
// Description : WIDTH-bit ALU with byte-serial load/read command port.
// Revision    : 1.0
// ============================================================================
module calc_core_param
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_cmd,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] flags
);

    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [3:0]       flags_q, flags_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    state_t           state_q, state_d;
    logic             is_mod_q, is_mod_d;

    logic             w_accept;
    logic [2:0]       w_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry, w_ovf, w_divzero, w_finish;
    logic             w_start, w_mode;
    logic             w_iter_busy, w_iter_done;
    logic [WIDTH-1:0] w_iter_lo, w_iter_hi;

    assign in_ready = ena & ~w_iter_busy;

    always_comb begin
        w_accept    = in_valid & in_ready;
        w_op        = in_data[2:0];
        w_sum       = {1'b0, a_q} + {1'b0, b_q};
        w_diff      = {1'b0, a_q} - {1'b0, b_q};
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        flags_d     = flags_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        state_d     = state_q;
        is_mod_d    = is_mod_q;
        w_start     = 1'b0;
        w_mode      = MODE_MUL;
        w_res       = '0;
        w_carry     = 1'b0;
        w_ovf       = 1'b0;
        w_divzero   = 1'b0;
        w_finish    = 1'b0;

        if (w_accept) begin
            unique case (in_cmd)
                CMD_LDA: a_d = WIDTH'({a_q, in_data});
                CMD_LDB: b_d = WIDTH'({b_q, in_data});
                CMD_EXEC: begin
                    unique case (w_op)
                        OP_ADD: begin
                            w_res    = w_sum[WIDTH-1:0];
                            w_carry  = w_sum[WIDTH];
                            w_ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (w_sum[WIDTH-1] != a_q[WIDTH-1]);
                            w_finish = 1'b1;
                        end
                        OP_SUB: begin
                            w_res    = w_diff[WIDTH-1:0];
                            w_carry  = w_diff[WIDTH];
                            w_ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                       (w_diff[WIDTH-1] != a_q[WIDTH-1]);
                            w_finish = 1'b1;
                        end
                        OP_MUL: begin
                            w_start = 1'b1;
                            w_mode  = MODE_MUL;
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_MOD: begin
                            if (b_q == '0) begin
                                w_res     = (w_op == OP_DIV) ? '1 : a_q;
                                w_divzero = 1'b1;
                                w_finish  = 1'b1;
                            end else begin
                                w_start  = 1'b1;
                                w_mode   = MODE_DIV;
                                state_d  = ST_DIV;
                                is_mod_d = (w_op == OP_MOD);
                            end
                        end
                        OP_AND: begin
                            w_res    = a_q & b_q;
                            w_finish = 1'b1;
                        end
                        OP_OR: begin
                            w_res    = a_q | b_q;
                            w_finish = 1'b1;
                        end
                        OP_XOR: begin
                            w_res    = a_q ^ b_q;
                            w_finish = 1'b1;
                        end
                    endcase
                end
                CMD_RD: begin
                    // Rotate left one byte; NBYTES reads bring R back around.
                    out_data_d  = r_q[WIDTH-1 -: 8];
                    r_d         = WIDTH'({r_q, r_q} >> (8 * (NBYTES - 1)));
                    out_valid_d = 1'b1;
                end
            endcase
        end else if (w_iter_done) begin
            w_finish = 1'b1;
            state_d  = ST_IDLE;
            if (state_q == ST_DIV) begin
                w_res = is_mod_q ? w_iter_hi : w_iter_lo;
            end else begin
                w_res = w_iter_lo;
                w_ovf = |w_iter_hi;
            end
        end

        if (w_finish) begin
            r_d     = w_res;
            flags_d = pack_flags(w_divzero, w_ovf, w_carry, w_res == '0);
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            flags_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            state_q     <= ST_IDLE;
            is_mod_q    <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            flags_q     <= flags_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            state_q     <= state_d;
            is_mod_q    <= is_mod_d;
        end
    end

    calc_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (w_start),
        .mode  (w_mode),
        .a     (a_q),
        .b     (b_q),
        .busy  (w_iter_busy),
        .done  (w_iter_done),
        .lo    (w_iter_lo),
        .hi    (w_iter_hi)
    );

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = w_iter_busy;
    assign done      = done_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_core_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_core_param
// Description : Self-checking bench for calc_core_param at WIDTH 8/16/32.
// Revision    : 1.0
// ============================================================================
module tb_calc_core_param;
    import calc_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      ena;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready;
    logic [2:0][1:0] in_cmd;
    logic [2:0][7:0] in_data;
    logic [2:0][7:0] out_data;
    logic [2:0]      out_valid;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [2:0][3:0] flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Index 0/1/2 -> WIDTH 8/16/32
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        calc_core_param #(.WIDTH(8 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ena       (ena[gi]),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_cmd    (in_cmd[gi]),
            .in_data   (in_data[gi]),
            .out_data  (out_data[gi]),
            .out_valid (out_valid[gi]),
            .busy      (busy[gi]),
            .done      (done[gi]),
            .flags     (flags[gi])
        );
    end

    typedef struct {
        int               u;
        logic [2:0]       op;
        longint unsigned  a;
        longint unsigned  b;
        longint unsigned  r;
        logic [3:0]       f;
        int               bc;
        int               pause;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [1:0] cmd, input logic [7:0] data);
        int k;
        in_valid[u] = 1'b1;
        in_cmd[u]   = cmd;
        in_data[u]  = data;
        for (k = 0; k < 100; k++) begin
            if (in_ready[u]) break;
            tick();
        end
        if (k == 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: dut %0d got in_ready 0 expected 1", u);
        end
        tick();
        in_valid[u] = 1'b0;
    endtask

    task automatic load(input int u, input logic [1:0] cmd, input longint unsigned val);
        for (int i = (1 << u) - 1; i >= 0; i--) begin
            send(u, cmd, 8'(val >> (8 * i)));
        end
    endtask

    task automatic read_r(input int u, output longint unsigned r);
        r = 0;
        for (int i = 0; i < (1 << u); i++) begin
            send(u, CMD_RD, 8'h00);
            check("rd_valid", 64'(out_valid[u]), 64'd1);
            r = (r << 8) | 64'(out_data[u]);
        end
    endtask

    task automatic run_exec(input int u, input logic [2:0] op, input longint unsigned a,
                            input longint unsigned b, input int pause_at,
                            output longint unsigned r, output logic [3:0] f,
                            output int bc, output int lat);
        int k;
        load(u, CMD_LDA, a);
        load(u, CMD_LDB, b);
        send(u, CMD_EXEC, {5'b0, op});
        bc = 0;
        for (k = 0; k < 120; k++) begin
            if (k == pause_at) ena[u] = 1'b0;
            if (k == pause_at + 3) ena[u] = 1'b1;
            if (pause_at >= 0 && k == pause_at + 1)
                check("ena_low_ready", 64'(in_ready[u]), 64'd0);
            if (done[u]) break;
            if (busy[u]) bc++;
            tick();
        end
        ena[u] = 1'b1;
        lat = k + 1;
        f = flags[u];
        tick();
        check("done_one_cycle", 64'(done[u]), 64'd0);
        read_r(u, r);
    endtask

    task automatic run_vec(input string tag, input int u, input logic [2:0] op,
                           input longint unsigned a, input longint unsigned b,
                           input longint unsigned exp_r, input logic [3:0] exp_f,
                           input int exp_bc, input int pause_at);
        longint unsigned r;
        logic [3:0] f;
        int bc, lat;
        run_exec(u, op, a, b, pause_at, r, f, bc, lat);
        check({tag, "_result"}, r, exp_r);
        check({tag, "_flags"}, 64'(f), 64'(exp_f));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_bc));
        check({tag, "_latency"}, 64'(lat), 64'(exp_bc + 1));
    endtask

    // Arithmetic reference: operands as plain integers, signed view for ovf.
    function automatic void model(input int w, input logic [2:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned r, output logic [3:0] f,
                                  output int bc);
        longint unsigned mask, full;
        longint sa, sb, s, smax, smin;
        logic c, o, dz;
        mask = (64'd1 << w) - 64'd1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa = longint'(a);
        sb = longint'(b);
        if (sa > smax) sa = sa - (longint'(1) << w);
        if (sb > smax) sb = sb - (longint'(1) << w);
        c = 1'b0; o = 1'b0; dz = 1'b0; bc = 0; r = 0;
        case (op)
            OP_ADD: begin
                full = a + b;
                r = full & mask;
                c = (full >> w) != 0;
                s = sa + sb;
                o = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                r = (a - b) & mask;
                c = a < b;
                s = sa - sb;
                o = (s > smax) || (s < smin);
            end
            OP_MUL: begin
                full = a * b;
                r = full & mask;
                o = (full >> w) != 0;
                bc = w;
            end
            OP_DIV: begin
                if (b == 0) begin r = mask; dz = 1'b1; end
                else begin r = a / b; bc = w; end
            end
            OP_MOD: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else begin r = a % b; bc = w; end
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            default: r = a ^ b;
        endcase
        f = {dz, o, c, (r == 0)};
    endfunction

    function automatic longint unsigned pick(input int w);
        longint unsigned mask, v;
        mask = (64'd1 << w) - 64'd1;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 4))
            0: return 0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            default: return v & mask;
        endcase
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned r, ra, rb, er;
        logic [3:0] ef;
        int ebc, k;
        logic blocked_ok, done_seen;

        tbl[0]  = '{1, OP_ADD, 64'h1234, 64'h0022, 64'h1256, 4'b0000, 0, -1};
        tbl[1]  = '{1, OP_SUB, 64'h0001, 64'h0002, 64'hFFFF, 4'b0010, 0, -1};
        tbl[2]  = '{1, OP_ADD, 64'h7FFF, 64'h0001, 64'h8000, 4'b0100, 0, -1};
        tbl[3]  = '{1, OP_MUL, 64'h0100, 64'h0100, 64'h0000, 4'b0101, 16, -1};
        tbl[4]  = '{1, OP_DIV, 64'h03E8, 64'h0007, 64'h008E, 4'b0000, 16, -1};
        tbl[5]  = '{1, OP_MOD, 64'h03E8, 64'h0007, 64'h0006, 4'b0000, 16, -1};
        tbl[6]  = '{1, OP_DIV, 64'h03E8, 64'h0007, 64'h008E, 4'b0000, 19, 5};
        tbl[7]  = '{1, OP_DIV, 64'h1234, 64'h0000, 64'hFFFF, 4'b1000, 0, -1};
        tbl[8]  = '{1, OP_MOD, 64'h1234, 64'h0000, 64'h1234, 4'b1000, 0, -1};
        tbl[9]  = '{0, OP_ADD, 64'h7F, 64'h01, 64'h80, 4'b0100, 0, -1};
        tbl[10] = '{0, OP_MUL, 64'h10, 64'h10, 64'h00, 4'b0101, 8, -1};
        tbl[11] = '{0, OP_MUL, 64'h0F, 64'h0E, 64'hD2, 4'b0000, 8, -1};
        tbl[12] = '{2, OP_ADD, 64'hFFFFFFFF, 64'h1, 64'h0, 4'b0011, 0, -1};
        tbl[13] = '{2, OP_MUL, 64'h10000, 64'h10000, 64'h0, 4'b0101, 32, -1};
        tbl[14] = '{2, OP_MUL, 64'h12345678, 64'h2, 64'h2468ACF0, 4'b0000, 32, -1};

        rst = 1'b1;
        ena = 3'b111;
        in_valid = '0;
        in_cmd = '0;
        in_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        for (int u = 0; u < 3; u++) begin
            check("reset_busy", 64'(busy[u]), 64'd0);
            check("reset_done", 64'(done[u]), 64'd0);
            check("reset_flags", 64'(flags[u]), 64'd0);
            check("reset_out_data", 64'(out_data[u]), 64'd0);
            check("reset_in_ready", 64'(in_ready[u]), 64'd1);
            read_r(u, r);
            check("reset_r", r, 64'd0);
        end

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].u, tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].r, tbl[i].f, tbl[i].bc, tbl[i].pause);
        end

        // NBYTES reads must leave R unchanged
        read_r(1, r);
        check("rd_restore", r, 64'h1234);

        // Command held through a MUL is taken only in the done cycle
        load(1, CMD_LDA, 64'h0003);
        load(1, CMD_LDB, 64'h0005);
        send(1, CMD_EXEC, {5'b0, OP_MUL});
        in_valid[1] = 1'b1;
        in_cmd[1] = CMD_RD;
        in_data[1] = 8'h00;
        blocked_ok = 1'b1;
        for (k = 0; k < 40; k++) begin
            if (done[1]) break;
            if (in_ready[1]) blocked_ok = 1'b0;
            tick();
        end
        check("hs_wait_cycles", 64'(k), 64'd16);
        check("hs_blocked", 64'(blocked_ok), 64'd1);
        check("hs_ready_in_done", 64'(in_ready[1]), 64'd1);
        tick();
        in_valid[1] = 1'b0;
        check("hs_rd_valid", 64'(out_valid[1]), 64'd1);
        check("hs_rd_hi", 64'(out_data[1]), 64'h00);
        send(1, CMD_RD, 8'h00);
        check("hs_rd_lo", 64'(out_data[1]), 64'h0F);

        // Asynchronous reset mid-MUL
        run_vec("pre_abort", 1, OP_SUB, 64'h1, 64'h2, 64'hFFFF, 4'b0010, 0, -1);
        load(1, CMD_LDA, 64'h0005);
        load(1, CMD_LDB, 64'h0007);
        send(1, CMD_EXEC, {5'b0, OP_MUL});
        repeat (4) tick();
        check("abort_busy_before", 64'(busy[1]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy[1]), 64'd0);
        check("abort_done", 64'(done[1]), 64'd0);
        check("abort_flags", 64'(flags[1]), 64'd0);
        check("abort_out_data", 64'(out_data[1]), 64'd0);
        check("abort_out_valid", 64'(out_valid[1]), 64'd0);
        tick();
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done != 3'b000) done_seen = 1'b1;
            tick();
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        read_r(1, r);
        check("abort_r", r, 64'd0);

        // Random operations against the arithmetic model
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 20; i++) begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 7));
                ra = pick(8 << u);
                rb = pick(8 << u);
                model(8 << u, op, ra, rb, er, ef, ebc);
                run_vec($sformatf("rnd_w%0d_op%0d", 8 << u, op), u, op, ra, rb, er, ef, ebc, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
